// File: rtl/tjmono2_rx_arbiter.sv
// Round-robin merger of CHANNELS FWFT receiver FIFOs into one tagged 32-bit readout stream,
// with optional per-burst timestamp words and per-channel saturating overflow counters.
module tjmono2_rx_arbiter #(
  parameter int CHANNELS  = 4,   // 1..15, ID 15 is reserved for timestamp words
  parameter int MAX_BURST = 16   // 1..255
) (
  input  logic                     BUS_CLK,
  input  logic                     BUS_RST_N,
  input  logic [28*CHANNELS-1:0]   CH_DATA,
  input  logic [CHANNELS-1:0]      CH_EMPTY,
  output logic [CHANNELS-1:0]      CH_READ,
  input  logic [CHANNELS-1:0]      CH_FULL,
  input  logic [CHANNELS-1:0]      EN_MASK,
  input  logic                     TS_MODE,
  input  logic [27:0]              TIMESTAMP,
  input  logic                     CLR_CNT,
  output logic [31:0]              OUT_DATA,
  output logic                     OUT_VALID,
  input  logic                     OUT_READY,
  output logic [8*CHANNELS-1:0]    LOST_CNT,
  output logic [3:0]               GRANT
);

  typedef enum logic [1:0] {IDLE, TS, DATA} state_t;

  localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);
  localparam logic [3:0] LAST_CH    = 4'(CHANNELS - 1);

  state_t              state;
  logic [3:0]          ptr;
  logic [3:0]          grant;
  logic [7:0]          burst_cnt;
  logic [CHANNELS-1:0] full_q;
  logic [7:0]          lost_cnt [CHANNELS];

  logic                load;
  logic [CHANNELS-1:0] cand;
  logic [CHANNELS-1:0] grant_sel;
  logic                grant_empty;
  logic                grant_en;
  logic [27:0]         grant_data;
  logic                pop;
  logic                found;
  logic [3:0]          winner;
  logic [3:0]          next_ptr;

  always_comb begin
    load      = !OUT_VALID || OUT_READY;
    cand      = EN_MASK & ~CH_EMPTY;
    grant_sel = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      grant_sel[i] = (grant == 4'(i));
    end
    grant_empty = |(CH_EMPTY & grant_sel);
    grant_en    = |(EN_MASK & grant_sel);
    grant_data  = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (grant_sel[i]) grant_data = CH_DATA[28*i +: 28];
    end
    pop      = (state == DATA) && load && !grant_empty && grant_en;
    CH_READ  = pop ? grant_sel : '0;
    next_ptr = (grant >= LAST_CH) ? 4'd0 : grant + 4'd1;
  end

  // First pass covers ptr..CHANNELS-1, second pass wraps around to 0..ptr-1.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (!found && cand[i] && (i >= int'(ptr))) begin
        found  = 1'b1;
        winner = 4'(i);
      end
    end
    for (int i = 0; i < CHANNELS; i++) begin
      if (!found && cand[i]) begin
        found  = 1'b1;
        winner = 4'(i);
      end
    end
  end

  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) begin
      state     <= IDLE;
      ptr       <= '0;
      grant     <= '0;
      burst_cnt <= '0;
      OUT_VALID <= 1'b0;
      OUT_DATA  <= '0;
    end else begin
      if (load) begin
        if (state == TS) begin
          OUT_VALID <= 1'b1;
          OUT_DATA  <= {4'hF, TIMESTAMP};
        end else if (pop) begin
          OUT_VALID <= 1'b1;
          OUT_DATA  <= {grant, grant_data};
        end else begin
          OUT_VALID <= 1'b0;
        end
      end

      case (state)
        IDLE: begin
          if (found) begin
            grant     <= winner;
            burst_cnt <= '0;
            state     <= TS_MODE ? TS : DATA;
          end
        end
        TS: begin
          if (load) state <= DATA;
        end
        DATA: begin
          if (pop) burst_cnt <= burst_cnt + 8'd1;
          // Ending on the last pop itself keeps the inter-burst gap at one cycle.
          if (grant_empty || !grant_en || (pop && burst_cnt == BURST_LAST)) begin
            state <= IDLE;
            ptr   <= next_ptr;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) begin
      full_q <= '0;
      for (int i = 0; i < CHANNELS; i++) lost_cnt[i] <= '0;
    end else begin
      full_q <= CH_FULL;
      for (int i = 0; i < CHANNELS; i++) begin
        if (CLR_CNT) begin
          lost_cnt[i] <= '0;
        end else if (CH_FULL[i] && !full_q[i] && (lost_cnt[i] != 8'hFF)) begin
          lost_cnt[i] <= lost_cnt[i] + 8'd1;
        end
      end
    end
  end

  always_comb begin
    LOST_CNT = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      LOST_CNT[8*i +: 8] = lost_cnt[i];
    end
  end

  assign GRANT = grant;

endmodule

// File: tb/tb_tjmono2_rx_arbiter.sv
// Directed bench for tjmono2_rx_arbiter: FIFO model per channel, output word log, hand-computed expectations.
module tb_tjmono2_rx_arbiter;

  localparam int CH = 4;
  localparam int MB = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [28*CH-1:0]  CH_DATA;
  logic [CH-1:0]     CH_EMPTY;
  logic [CH-1:0]     CH_READ;
  logic [CH-1:0]     CH_FULL;
  logic [CH-1:0]     EN_MASK;
  logic              TS_MODE;
  logic [27:0]       TIMESTAMP;
  logic              CLR_CNT;
  logic [31:0]       OUT_DATA;
  logic              OUT_VALID;
  logic              OUT_READY;
  logic [8*CH-1:0]   LOST_CNT;
  logic [3:0]        GRANT;

  always #5 clk = ~clk;

  tjmono2_rx_arbiter #(.CHANNELS(CH), .MAX_BURST(MB)) dut (
    .BUS_CLK(clk), .BUS_RST_N(rst_n), .CH_DATA(CH_DATA), .CH_EMPTY(CH_EMPTY),
    .CH_READ(CH_READ), .CH_FULL(CH_FULL), .EN_MASK(EN_MASK), .TS_MODE(TS_MODE),
    .TIMESTAMP(TIMESTAMP), .CLR_CNT(CLR_CNT), .OUT_DATA(OUT_DATA), .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY), .LOST_CNT(LOST_CNT), .GRANT(GRANT)
  );

  int errors = 0;
  int checks = 0;
  int fifoCnt [CH];
  int popped [CH];
  int readCount [CH];
  int oneHotViol = 0;
  int emptyReadViol = 0;
  int cyc = 0;
  int base;
  logic [CH-1:0] rdSample;
  logic [31:0] words[$];
  int wordCyc[$];
  int expId [12] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 1, 2, 3};

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Head word of channel i is {i, A5, number of words already popped}.
  task automatic applyStimulus();
    for (int i = 0; i < CH; i++) begin
      CH_EMPTY[i] = (fifoCnt[i] == 0);
      CH_DATA[28*i +: 28] = {4'(i), 8'hA5, 16'(popped[i])};
    end
  endtask

  task automatic tick();
    @(negedge clk);
    rdSample = CH_READ;
    if ($countones(rdSample) > 1) oneHotViol++;
    if (OUT_VALID && OUT_READY) begin
      words.push_back(OUT_DATA);
      wordCyc.push_back(cyc);
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < CH; i++) begin
      if (rdSample[i]) begin
        readCount[i]++;
        if (fifoCnt[i] > 0) begin
          fifoCnt[i]--;
          popped[i]++;
        end else begin
          emptyReadViol++;
        end
      end
    end
    applyStimulus();
  endtask

  task automatic clearLog();
    words.delete();
    wordCyc.delete();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < CH; i++) begin
      fifoCnt[i] = 3;
      popped[i] = 0;
      readCount[i] = 0;
    end
    CH_FULL = '0;
    EN_MASK = '1;
    TS_MODE = 1'b0;
    TIMESTAMP = 28'h0;
    CLR_CNT = 1'b0;
    OUT_READY = 1'b1;
    applyStimulus();

    // Reset held with data available
    for (int n = 0; n < 3; n++) begin
      tick();
      checkOutput("reset_valid", 32'(OUT_VALID), 32'd0);
      checkOutput("reset_read", 32'(rdSample), 32'd0);
      checkOutput("reset_lost", LOST_CNT, 32'd0);
    end
    checkOutput("reset_data", OUT_DATA, 32'd0);
    rst_n = 1'b1;

    // Round robin, MAX_BURST=2, three words per channel
    for (int n = 0; n < 40; n++) tick();
    checkOutput("rr_count", 32'(words.size()), 32'd12);
    for (int k = 0; k < 12 && k < words.size(); k++) begin
      checkOutput($sformatf("rr_id%0d", k), 32'(words[k][31:28]), 32'(expId[k]));
    end
    if (words.size() >= 9) begin
      checkOutput("rr_first", words[0], 32'h00A50000);
      checkOutput("rr_word8", words[8], 32'h00A50002);
      checkOutput("rr_b2b", 32'(wordCyc[1] - wordCyc[0]), 32'd1);
      checkOutput("rr_gap", 32'(wordCyc[2] - wordCyc[1]), 32'd2);
    end
    checkOutput("rr_reads", 32'(readCount[0] + readCount[1] + readCount[2] + readCount[3]), 32'd12);
    clearLog();

    // Timestamp header before a one-word burst on channel 2
    TS_MODE = 1'b1;
    TIMESTAMP = 28'h0ABCDEF;
    base = readCount[2];
    fifoCnt[2] = 1;
    applyStimulus();
    for (int n = 0; n < 12; n++) tick();
    checkOutput("ts_count", 32'(words.size()), 32'd2);
    if (words.size() >= 2) begin
      checkOutput("ts_word", words[0], 32'hF0ABCDEF);
      checkOutput("ts_data", words[1], 32'h22A50003);
    end
    checkOutput("ts_reads", 32'(readCount[2] - base), 32'd1);
    checkOutput("ts_grant", 32'(GRANT), 32'd2);
    TS_MODE = 1'b0;
    clearLog();

    // Backpressure for five cycles mid-burst on channel 0
    fifoCnt[0] = 3;
    applyStimulus();
    for (int n = 0; n < 20 && !OUT_VALID; n++) tick();
    checkOutput("stall_reach", 32'(OUT_VALID), 32'd1);
    OUT_READY = 1'b0;
    for (int n = 0; n < 5; n++) begin
      tick();
      checkOutput("stall_data", OUT_DATA, 32'h00A50003);
      checkOutput("stall_valid", 32'(OUT_VALID), 32'd1);
      checkOutput("stall_read", 32'(rdSample), 32'd0);
    end
    OUT_READY = 1'b1;
    for (int n = 0; n < 12; n++) tick();
    checkOutput("stall_count", 32'(words.size()), 32'd3);
    if (words.size() >= 3) begin
      checkOutput("stall_w0", words[0], 32'h00A50003);
      checkOutput("stall_w1", words[1], 32'h00A50004);
      checkOutput("stall_w2", words[2], 32'h00A50005);
    end
    clearLog();

    // Channel 1 disabled right after its first pop
    fifoCnt[1] = 3;
    fifoCnt[2] = 1;
    applyStimulus();
    rdSample = '0;
    for (int n = 0; n < 20 && !rdSample[1]; n++) tick();
    checkOutput("en_firstpop", 32'(rdSample[1]), 32'd1);
    EN_MASK[1] = 1'b0;
    base = readCount[1];
    for (int n = 0; n < 15; n++) tick();
    checkOutput("en_noread", 32'(readCount[1] - base), 32'd0);
    checkOutput("en_grant", 32'(GRANT), 32'd2);
    checkOutput("en_count", 32'(words.size()), 32'd2);
    if (words.size() >= 2) begin
      checkOutput("en_w0", words[0], 32'h11A50003);
      checkOutput("en_w1", words[1], 32'h22A50004);
    end
    EN_MASK[1] = 1'b1;
    for (int n = 0; n < 15; n++) tick();
    checkOutput("en_count2", 32'(words.size()), 32'd4);
    if (words.size() >= 4) begin
      checkOutput("en_w2", words[2], 32'h11A50004);
      checkOutput("en_w3", words[3], 32'h11A50005);
    end
    clearLog();

    checkOutput("onehot", 32'(oneHotViol), 32'd0);
    checkOutput("empty_read", 32'(emptyReadViol), 32'd0);

    // Overflow counters: count, saturate, clear with priority
    for (int n = 0; n < 10; n++) begin
      CH_FULL[3] = 1'b1; tick();
      CH_FULL[3] = 1'b0; tick();
    end
    checkOutput("lost_10", 32'(LOST_CNT[31:24]), 32'd10);
    checkOutput("lost_other", 32'(LOST_CNT[23:0]), 32'd0);
    for (int n = 0; n < 290; n++) begin
      CH_FULL[3] = 1'b1; tick();
      CH_FULL[3] = 1'b0; tick();
    end
    checkOutput("lost_sat", 32'(LOST_CNT[31:24]), 32'd255);
    CH_FULL[3] = 1'b1;
    CLR_CNT = 1'b1;
    tick();
    checkOutput("lost_clr", 32'(LOST_CNT[31:24]), 32'd0);
    CLR_CNT = 1'b0;
    tick();
    checkOutput("lost_level", 32'(LOST_CNT[31:24]), 32'd0);
    CH_FULL[3] = 1'b0; tick();
    CH_FULL[3] = 1'b1; tick();
    CH_FULL[3] = 1'b0;
    checkOutput("lost_after", 32'(LOST_CNT[31:24]), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tjmono2_rx_arbiter.md
# tjmono2_rx_arbiter

- Multi-channel successor to the single-link TJ-Monopix2 receiver core's FIFO output stage.
- Merges CHANNELS first-word-fall-through receiver FIFOs (28-bit FE words) into one 32-bit stream for the readout FIFO. Each word is tagged with its channel number.
- Arbitration is round-robin with a bounded burst length and a per-channel enable mask.
- Optional timestamp header per burst; per-channel saturating overflow counters.
- Sits between the per-link receiver logic and the shared readout FIFO/arbiter, in the BUS_CLK domain.

## Interface
Parameters:
- CHANNELS, 4, number of receiver channels; legal range 1..15.
- MAX_BURST, 16, maximum data words taken from one channel per grant; legal range 1..255.

Ports:
- BUS_CLK  in  1  sole clock; all logic rising-edge.
- BUS_RST_N  in  1  reset, asynchronous assert, active-low.
- CH_DATA  in  28*CHANNELS  FWFT head word of channel i at bits [28*i+27:28*i].
- CH_EMPTY  in  CHANNELS  channel FIFO empty.
- CH_READ  out  CHANNELS  pop strobe, one-hot or zero, combinational.
- CH_FULL  in  CHANNELS  channel FIFO full/overflow flag.
- EN_MASK  in  CHANNELS  channel enable.
- TS_MODE  in  1  insert a timestamp word before each burst.
- TIMESTAMP  in  28  free-running timestamp.
- CLR_CNT  in  1  synchronous clear of all lost counters.
- OUT_DATA  out  32  merged word.
- OUT_VALID  out  1  OUT_DATA valid.
- OUT_READY  in  1  downstream accepts word.
- LOST_CNT  out  8*CHANNELS  per-channel saturating overflow-event counter.
- GRANT  out  4  channel currently granted (debug).

## Operation
Output word format:
- Data word: {ch[3:0], CH_DATA[ch]}.
- Timestamp word: {4'hF, TIMESTAMP}. ID 15 is reserved for timestamps, so CHANNELS ≤ 15.

Output register:
- Single stage. load = !OUT_VALID | OUT_READY.
- While OUT_VALID=1 and OUT_READY=0, OUT_DATA and OUT_VALID hold stable.

FSM states: IDLE, TS, DATA.
- IDLE
  - Candidates are channels with EN_MASK[i]=1 and CH_EMPTY[i]=0.
  - Search starts at ptr and wraps modulo CHANNELS; the first candidate wins.
  - On a win: register GRANT=winner, clear burst_cnt, go to TS if TS_MODE=1, else DATA.
  - No candidate: stay in IDLE.
- TS
  - When load=1: capture the timestamp word (TIMESTAMP sampled at that edge) and go to DATA.
  - Otherwise hold in TS.
- DATA
  - When load=1, CH_EMPTY[GRANT]=0 and EN_MASK[GRANT]=1: assert CH_READ[GRANT], capture the data word, increment burst_cnt.
  - Return to IDLE when burst_cnt reaches MAX_BURST, when CH_EMPTY[GRANT]=1, or when EN_MASK[GRANT]=0. On that return, ptr = (GRANT+1) mod CHANNELS.
  - If the channel empties or is disabled, no pop occurs in that cycle.
  - A TS word already emitted is not retracted, even if the burst then contains no data.

Lost counters:
- Each channel increments on a rising edge of CH_FULL[i] (registered previous value); the counter saturates at 255.
- CLR_CNT has priority over an increment in the same cycle: the result is 0.

CH_READ is never asserted outside DATA, never asserted while load=0, and never asserted to an empty channel.

## Timing
Reset values:
- FSM=IDLE, ptr=0, GRANT=0, burst_cnt=0.
- OUT_VALID=0, OUT_DATA=0, LOST_CNT=0, CH_FULL history=0.
- CH_READ=0, since it is decoded from the registered state.

Latency:
- Candidate visible before edge k while in IDLE: state changes at edge k.
  - TS_MODE=0: CH_READ high during cycle k; OUT_VALID=1 after edge k+1.
  - TS_MODE=1: timestamp word valid after edge k+1; first data word after edge k+2.

Throughput:
- One word per cycle within a burst while OUT_READY=1.
- One idle cycle (IDLE state) between bursts.

Reset mid-burst: a word held in the output register is discarded, and the popped word is lost.

Simultaneous events:
- EN_MASK dropped in the same cycle as a pop: no pop.
- Channel empties as MAX_BURST is reached: single transition to IDLE.

## Test plan
- Reset with CH_EMPTY=0, EN_MASK all ones -> OUT_VALID=0, CH_READ=0, LOST_CNT=0 until release; the first word after release carries ID 0.
- CHANNELS=4, MAX_BURST=2, all channels hold 3 words, TS_MODE=0, OUT_READY=1 -> ID sequence 0,0,1,1,2,2,3,3,0,1,2,3; exactly one CH_READ per output word; a 1-cycle gap between bursts.
- TS_MODE=1, TIMESTAMP=28'h0ABCDEF at grant, channel 2 holds one word -> F0ABCDEF then 2xxxxxxx; then IDLE.
- OUT_READY held 0 for 5 cycles mid-burst -> OUT_DATA stable, no CH_READ pulses; the burst resumes with no duplicate or dropped word.
- EN_MASK[1] cleared mid-burst -> no further CH_READ[1]; grant moves to channel 2; channel 1 is skipped until re-enabled.
- CH_FULL[3] pulsed 300 times -> LOST_CNT[3]=255; CLR_CNT coincident with a pulse -> 0.
